// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational ALU between the execute stage (requester 0) and the
// branch/address-generation path (requester 1). Round-robin arbitration on a
// valid/ready request channel; granted operands are registered and drive the
// ALU; the ALU result is captured and returned on a held response channel
// tagged with the requester id.
//
// Build option: define ALU_ARB_B2B_EN to let arbitration also run in the
// response cycle where rsp_ready is high, so a new request is accepted on the
// same edge that retires the response (one result every 2 cycles instead of 3).
//
// Handshake rules (request and response channels alike): a transfer happens
// on a rising edge where valid and ready are both high. The sender holds
// valid and payload stable until that edge. Ready never waits on a future
// valid, and the receiver only samples payload on the transfer edge.
//
// FSM state is visible on dbg_state (0 = IDLE, 1 = EXEC, 2 = RESP).

module alu_share_arbiter #(
  parameter int DATA_W  = 32,
  parameter bit RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [4:0]        req0_opcode,
  input  logic [4:0]        req1_opcode,
  input  logic [2:0]        req0_func3,
  input  logic [2:0]        req1_func3,
  input  logic              req0_func7,
  input  logic              req1_func7,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  output logic [4:0]        alu_opcode,
  output logic [2:0]        alu_func3,
  output logic              alu_func7,
  output logic [DATA_W-1:0] alu_operand1,
  output logic [DATA_W-1:0] alu_operand2,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic              busy,
  output logic [1:0]        dbg_state
);

`ifdef ALU_ARB_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_rr_ptr;
  logic                r_id;
  logic [4:0]          r_opcode;
  logic [2:0]          r_func3;
  logic                r_func7;
  logic [DATA_W-1:0]   r_op1;
  logic [DATA_W-1:0]   r_op2;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_data;

  logic                w_arb_open;
  logic                w_win1;
  logic                w_grant;
  logic [4:0]          w_sel_opcode;
  logic [2:0]          w_sel_func3;
  logic                w_sel_func7;
  logic [DATA_W-1:0]   w_sel_op1;
  logic [DATA_W-1:0]   w_sel_op2;

  // Arbitration window: IDLE, or the retiring RESP cycle when back-to-back is
  // built in. Held closed during reset so no requester sees ready.
  assign w_arb_open = rst_n &&
                      ((r_state == S_IDLE) ||
                       (B2B && (r_state == S_RESP) && rsp_ready));

  // Requester 1 wins when it is alone, or when both are valid and it holds priority.
  assign w_win1  = req1_valid && (!req0_valid || r_rr_ptr);
  assign w_grant = w_arb_open && (req0_valid || req1_valid);

  assign req0_ready = w_grant && !w_win1;
  assign req1_ready = w_grant &&  w_win1;

  // Payload of the current winner, only consumed on a grant edge.
  always_comb begin
    w_sel_opcode = req0_opcode;
    w_sel_func3  = req0_func3;
    w_sel_func7  = req0_func7;
    w_sel_op1    = req0_op1;
    w_sel_op2    = req0_op2;
    if (w_win1) begin
      w_sel_opcode = req1_opcode;
      w_sel_func3  = req1_func3;
      w_sel_func7  = req1_func7;
      w_sel_op1    = req1_op1;
      w_sel_op2    = req1_op2;
    end
  end

  // Control FSM with registered ALU drive and response channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= RR_INIT;
      r_id        <= 1'b0;
      r_opcode    <= '0;
      r_func3     <= '0;
      r_func7     <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      // A grant can only occur in IDLE or in a retiring RESP cycle.
      if (w_grant) begin
        r_opcode <= w_sel_opcode;
        r_func3  <= w_sel_func3;
        r_func7  <= w_sel_func7;
        r_op1    <= w_sel_op1;
        r_op2    <= w_sel_op2;
        r_id     <= w_win1;
        r_rr_ptr <= ~w_win1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_grant) r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_rsp_data  <= alu_out;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_grant ? S_EXEC : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_opcode   = r_opcode;
  assign alu_func3    = r_func3;
  assign alu_func7    = r_func7;
  assign alu_operand1 = r_op1;
  assign alu_operand2 = r_op2;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_data     = r_rsp_data;
  assign busy         = (r_state != S_IDLE);
  assign dbg_state    = r_state;

endmodule
